ahb_calc_top: RTL and testbench

//  AHB-Lite slave wrapping a 32-bit register-programmed calculator. The host writes

---
 rtl/ahb_calc_top.sv | 136 +++++++++++++
 tb/tb_ahb_calc_top.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ahb_calc_top.sv
// AHB-Lite zero-wait-state slave around a register-programmed 32-bit calculator.
// Host programs MODE/OPA/OPB, pulses START via CTRL, then reads RESULT/STATUS.
module ahb_calc_top #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hsel,
    input  logic              hwrite,
    input  logic              hready,
    input  logic [2:0]        hsize,
    input  logic [1:0]        htrans,
    input  logic [2:0]        hburst,
    input  logic [DATA_W-1:0] hwdata,
    input  logic [ADDR_W-1:0] haddr,
    output logic              hready_resp,
    output logic [1:0]        hresp,
    output logic [DATA_W-1:0] hrdata
);

    localparam logic [5:0] A_CTRL   = 6'h00;
    localparam logic [5:0] A_MODE   = 6'h01;
    localparam logic [5:0] A_OPA    = 6'h02;
    localparam logic [5:0] A_OPB    = 6'h03;
    localparam logic [5:0] A_RESULT = 6'h04;
    localparam logic [5:0] A_STATUS = 6'h05;

    logic              wr_pend_q, wr_pend_d;
    logic [5:0]        wr_addr_q, wr_addr_d;
    logic [2:0]        mode_q, mode_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              done_q, done_d;
    logic              start_q, start_d;
    logic [DATA_W-1:0] hrdata_q, hrdata_d;
    logic              xfer_vld;
    logic [5:0]        rd_addr;
    logic [DATA_W-1:0] calc;

    // Size, burst, sequencing bit and non-decoded address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{hsize, hburst, htrans[0], haddr[ADDR_W-1:8], haddr[1:0]};

    assign hready_resp = 1'b1;
    assign hresp       = 2'b00;
    assign hrdata      = hrdata_q;
    assign xfer_vld    = hsel & hready & htrans[1];
    assign rd_addr     = haddr[7:2];

    // Calculator datapath on the architectural register values.
    always_comb begin
        calc = '0;
        case (mode_q)
            3'd0: calc = opa_q & opb_q;
            3'd1: calc = opa_q | opb_q;
            3'd2: calc = opa_q ^ opb_q;
            3'd3: calc = opa_q + opb_q;
            3'd4: calc = opa_q - opb_q;
            3'd5: calc = opa_q[15:0] * opb_q[15:0];
            3'd6: calc = opa_q << opb_q[4:0];
            3'd7: calc = opa_q >> opb_q[4:0];
            default: calc = '0;
        endcase
    end

    // Address-phase capture, data-phase commit, start/done sequencing and read mux.
    // The read mux looks at the post-commit (_d) values so a write followed
    // directly by a read of the same register returns the new data.
    always_comb begin
        wr_pend_d = xfer_vld & hwrite;
        wr_addr_d = (xfer_vld & hwrite) ? haddr[7:2] : wr_addr_q;
        mode_d    = mode_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        start_d   = 1'b0;
        result_d  = result_q;
        done_d    = done_q;
        hrdata_d  = hrdata_q;

        if (wr_pend_q) begin
            case (wr_addr_q)
                A_CTRL:  start_d = hwdata[0];
                A_MODE:  mode_d  = hwdata[2:0];
                A_OPA:   opa_d   = hwdata;
                A_OPB:   opb_d   = hwdata;
                default: ;
            endcase
        end

        if (start_q) begin
            result_d = calc;
            done_d   = 1'b1;
        end
        // A fresh START drops DONE for the cycle before the new result lands.
        if (start_d) done_d = 1'b0;

        if (xfer_vld & ~hwrite) begin
            case (rd_addr)
                A_MODE:   hrdata_d = {{(DATA_W-3){1'b0}}, mode_d};
                A_OPA:    hrdata_d = opa_d;
                A_OPB:    hrdata_d = opb_d;
                A_RESULT: hrdata_d = result_q;
                A_STATUS: hrdata_d = {{(DATA_W-1){1'b0}}, done_q};
                default:  hrdata_d = '0;
            endcase
        end
    end

    // State registers; reset also cancels any pending write.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            mode_q    <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            hrdata_q  <= '0;
        end else begin
            wr_pend_q <= wr_pend_d;
            wr_addr_q <= wr_addr_d;
            mode_q    <= mode_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            done_q    <= done_d;
            start_q   <= start_d;
            hrdata_q  <= hrdata_d;
        end
    end

endmodule

// File: tb/tb_ahb_calc_top.sv
// Directed bench for ahb_calc_top: register access, gating, every MODE, reset.
module tb_ahb_calc_top;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel, hwrite, hready;
    logic [2:0]  hsize, hburst;
    logic [1:0]  htrans;
    logic [31:0] hwdata, haddr;
    logic        hready_resp;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    int total = 0;
    int bad   = 0;
    logic [31:0] rd;

    ahb_calc_top #(.ADDR_W(32), .DATA_W(32)) dut (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .hwrite(hwrite),
        .hready(hready), .hsize(hsize), .htrans(htrans), .hburst(hburst),
        .hwdata(hwdata), .haddr(haddr), .hready_resp(hready_resp),
        .hresp(hresp), .hrdata(hrdata)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        hsel = 1'b0; hwrite = 1'b0; htrans = 2'b00; hready = 1'b1;
    endtask

    // Address phase with selectable gating fields, then data phase.
    task automatic wr_g(input logic [31:0] a, input logic [31:0] d,
                        input logic s, input logic [1:0] t, input logic r);
        hsel = s; hwrite = 1'b1; htrans = t; hready = r; haddr = a;
        @(posedge hclk); #1;
        idle_bus(); hwdata = d;
        @(posedge hclk); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_g(a, d, 1'b1, 2'b10, 1'b1);
    endtask

    task automatic rdr(input logic [31:0] a, output logic [31:0] d);
        hsel = 1'b1; hwrite = 1'b0; htrans = 2'b10; hready = 1'b1; haddr = a;
        @(posedge hclk); #1;
        idle_bus();
        d = hrdata;
        @(posedge hclk); #1;
    endtask

    // START, checking DONE is low the cycle after the commit.
    task automatic go();
        wr(32'h00, 32'h1);
        rdr(32'h14, rd); chk("done_clr", rd, 32'h0);
    endtask

    task automatic calc(input string tag, input logic [2:0] m,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        wr(32'h04, {29'd0, m});
        wr(32'h08, a);
        wr(32'h0C, b);
        go();
        rdr(32'h10, rd); chk(tag, rd, exp);
        rdr(32'h14, rd); chk({tag, "_done"}, rd, 32'h1);
    endtask

    initial begin
        idle_bus(); hsize = 3'b010; hburst = 3'b000; hwdata = '0; haddr = '0;
        hresetn = 1'b0;
        #2;
        chk("rst_hready", {31'd0, hready_resp}, 32'h1);
        chk("rst_hresp", {30'd0, hresp}, 32'h0);
        chk("rst_hrdata", hrdata, 32'h0);
        repeat (2) @(posedge hclk);
        #1 hresetn = 1'b1;
        @(posedge hclk); #1;

        rdr(32'h04, rd); chk("rst_mode", rd, 32'h0);
        rdr(32'h14, rd); chk("rst_status", rd, 32'h0);

        // Register readback and unmapped / write-only offsets.
        wr(32'h08, 32'hA5A5_5A5A);
        rdr(32'h08, rd); chk("opa_rb", rd, 32'hA5A5_5A5A);
        repeat (3) @(posedge hclk);
        #1 chk("hrdata_hold", hrdata, 32'hA5A5_5A5A);
        rdr(32'h00, rd); chk("ctrl_rd0", rd, 32'h0);
        rdr(32'h20, rd); chk("unmap_rd0", rd, 32'h0);
        wr(32'h04, 32'hFFFF_FFFF);
        rdr(32'h04, rd); chk("mode_mask", rd, 32'h7);

        // Gated writes must not reach OPB.
        wr_g(32'h0C, 32'h1111_1111, 1'b0, 2'b10, 1'b1);
        wr_g(32'h0C, 32'h2222_2222, 1'b1, 2'b00, 1'b1);
        wr_g(32'h0C, 32'h3333_3333, 1'b1, 2'b10, 1'b0);
        wr_g(32'h0C, 32'h4444_4444, 1'b1, 2'b01, 1'b1);
        rdr(32'h0C, rd); chk("gate_opb", rd, 32'h0);
        wr_g(32'h0C, 32'h5555_5555, 1'b1, 2'b11, 1'b1);
        rdr(32'h0C, rd); chk("seq_opb", rd, 32'h5555_5555);

        // Back-to-back write then read of the same register.
        hsel = 1'b1; hwrite = 1'b1; htrans = 2'b10; haddr = 32'h0C;
        @(posedge hclk); #1;
        hwrite = 1'b0; haddr = 32'h0C; hwdata = 32'hDEAD_BEEF;
        @(posedge hclk); #1;
        idle_bus();
        chk("fwd_opb", hrdata, 32'hDEAD_BEEF);
        @(posedge hclk); #1;

        calc("and",  3'd0, 32'h0000_3254, 32'h0000_0000, 32'h0000_0000);
        calc("or",   3'd1, 32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF);
        calc("xor",  3'd2, 32'hFFFF_0000, 32'hF0F0_F0F0, 32'h0F0F_F0F0);
        calc("add",  3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
        calc("sub",  3'd4, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
        calc("mul",  3'd5, 32'h0001_0003, 32'hFFFF_0005, 32'h0000_000F);
        calc("mulw", 3'd5, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001);
        calc("shl",  3'd6, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002);
        calc("shr",  3'd7, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001);

        // Operand change after START leaves RESULT alone.
        wr(32'h08, 32'h0000_0000);
        rdr(32'h10, rd); chk("result_stable", rd, 32'h0000_0001);

        // Reset between START and the result read.
        wr(32'h04, 32'h3); wr(32'h08, 32'h10); wr(32'h0C, 32'h20);
        wr(32'h00, 32'h1);
        #2 hresetn = 1'b0;
        #1;
        chk("mid_rst_hrdata", hrdata, 32'h0);
        chk("mid_rst_hready", {31'd0, hready_resp}, 32'h1);
        @(posedge hclk); #1 hresetn = 1'b1;
        @(posedge hclk); #1;
        rdr(32'h10, rd); chk("mid_rst_result", rd, 32'h0);
        rdr(32'h14, rd); chk("mid_rst_done", rd, 32'h0);
        rdr(32'h08, rd); chk("mid_rst_opa", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
